// File: rtl/mem_ctrl_byte.sv
// Word-to-byte memory controller: turns one 32-bit read or masked write into
// four byte accesses on a synchronous byte-wide RAM, then pulses done.
module mem_ctrl_byte #(
    parameter int MEM_ADDR_W = 17
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_rw_flag,
    input  logic [31:0]           i_addr,
    output logic [31:0]           o_read_data,
    input  logic [31:0]           i_write_data,
    input  logic [3:0]            i_write_mask,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [MEM_ADDR_W-1:0] o_mem_addr,
    output logic [7:0]            o_mem_dout,
    output logic                  o_mem_we,
    input  logic [7:0]            i_mem_din
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                r_state, w_state;
    logic [2:0]            r_cnt, w_cnt;
    logic [MEM_ADDR_W-1:0] r_addr, w_addr;
    logic [31:0]           r_wdata, w_wdata;
    logic [3:0]            r_wmask, w_wmask;
    logic [31:0]           r_read_data, w_read_data;
    logic                  r_busy, w_busy;
    logic                  r_done, w_done;
    logic [MEM_ADDR_W-1:0] r_mem_addr, w_mem_addr;
    logic [7:0]            r_mem_dout, w_mem_dout;
    logic                  r_mem_we, w_mem_we;
    logic [1:0]            w_nxt_idx;
    logic [MEM_ADDR_W-1:0] w_nxt_addr;

    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Byte index for the access issued at the coming edge; address wraps naturally
    assign w_nxt_idx  = r_cnt[1:0] + 2'd1;
    assign w_nxt_addr = r_addr + MEM_ADDR_W'(w_nxt_idx);

    // Next-state and next-output logic
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_wmask     = r_wmask;
        w_read_data = r_read_data;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_dout  = r_mem_dout;
        w_mem_we    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((i_rw_flag == 2'd1) || (i_rw_flag == 2'd2)) begin
                    w_addr     = i_addr[MEM_ADDR_W-1:0];
                    w_wdata    = i_write_data;
                    w_wmask    = i_write_mask;
                    w_cnt      = 3'd0;
                    w_busy     = 1'b1;
                    w_mem_addr = i_addr[MEM_ADDR_W-1:0];
                    if (i_rw_flag == 2'd1) begin
                        w_state = ST_READ;
                    end else begin
                        w_state    = ST_WRITE;
                        w_mem_dout = i_write_data[7:0];
                        w_mem_we   = i_write_mask[0];
                    end
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_READ: begin
                // RAM data lags its address by one edge, so capture trails issue by one count
                w_cnt = r_cnt + 3'd1;
                case (r_cnt)
                    3'd0: w_mem_addr = w_nxt_addr;
                    3'd1: begin
                        w_mem_addr        = w_nxt_addr;
                        w_read_data[7:0]  = i_mem_din;
                    end
                    3'd2: begin
                        w_mem_addr        = w_nxt_addr;
                        w_read_data[15:8] = i_mem_din;
                    end
                    3'd3: w_read_data[23:16] = i_mem_din;
                    3'd4: begin
                        w_read_data[31:24] = i_mem_din;
                        w_state            = ST_DONE;
                        w_busy             = 1'b0;
                        w_done             = 1'b1;
                    end
                    default: begin
                        w_state = ST_IDLE;
                        w_busy  = 1'b0;
                    end
                endcase
            end
            ST_WRITE: begin
                w_cnt = r_cnt + 3'd1;
                if (r_cnt < 3'd3) begin
                    w_mem_addr = w_nxt_addr;
                    w_mem_dout = byte_of(r_wdata, w_nxt_idx);
                    w_mem_we   = r_wmask[w_nxt_idx];
                end else begin
                    w_state = ST_DONE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end
            end
            ST_DONE: begin
                w_state = ST_IDLE;
                w_busy  = 1'b0;
            end
            default: begin
                w_state = ST_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_addr      <= '0;
            r_wdata     <= 32'h0000_0000;
            r_wmask     <= 4'h0;
            r_read_data <= 32'h0000_0000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_dout  <= 8'h00;
            r_mem_we    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_wmask     <= w_wmask;
            r_read_data <= w_read_data;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_mem_addr  <= w_mem_addr;
            r_mem_dout  <= w_mem_dout;
            r_mem_we    <= w_mem_we;
        end
    end

    assign o_read_data = r_read_data;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_dout  = r_mem_dout;
    assign o_mem_we    = r_mem_we;

endmodule
